truss_hdl_watchdog: RTL and testbench

HDL-side watchdog controller that drives the truss watchdog's `hdl_timeout_` / `hdl_timeout_count_` pair. It counts clock cycles since the last "kick" from any of NUM_SOURCES enabled activity sources and asserts `hdl_timeout_` when a programmed limit is reached. It sits in the testbench top, between DUT activity monitors and the watchdog interface, and arbitrates simultaneous kicks so the last active source is always known.

---
 rtl/truss_hdl_pkg.sv | 12 +
 rtl/truss_kick_prio_enc.sv | 22 ++
 rtl/truss_hdl_watchdog.sv | 130 +++++++++++++
 tb/tb_truss_hdl_watchdog.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/truss_hdl_pkg.sv
// Shared types and constants for the HDL-side truss watchdog.
package truss_hdl_pkg;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_ARMED   = 2'd1,
        WD_EXPIRED = 2'd2
    } wd_state_t;

    localparam int unsigned EXPIRY_CNT_W = 8;

endpackage

// File: rtl/truss_kick_prio_enc.sv
// Fixed-priority encoder: reports whether any kick is set and the lowest set index.
module truss_kick_prio_enc #(
    parameter int unsigned NUM_SOURCES = 4,
    localparam int unsigned SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic [NUM_SOURCES-1:0] req,
    output logic                   any_kick,
    output logic [SRC_W-1:0]       index
);

    always_comb begin
        any_kick = |req;
        index    = '0;
        // Walk downwards so the lowest set index is the one left standing.
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/truss_hdl_watchdog.sv
// Cycle-counting watchdog driving the truss hdl_timeout_/hdl_timeout_count_ pair.
module truss_hdl_watchdog
    import truss_hdl_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned NUM_SOURCES   = 4,
    localparam int unsigned SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [COUNTER_WIDTH-1:0] cfg_limit,
    input  logic [NUM_SOURCES-1:0]   cfg_src_en,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic [NUM_SOURCES-1:0]   kick,
    output logic                     hdl_timeout_,
    output logic [COUNTER_WIDTH-1:0] hdl_timeout_count_,
    output logic [SRC_W-1:0]         last_src,
    output logic [EXPIRY_CNT_W-1:0]  expiries,
    output logic [1:0]               state
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [EXPIRY_CNT_W-1:0]  EXP_MAX = '1;
    localparam logic [EXPIRY_CNT_W-1:0]  EXP_ONE = EXPIRY_CNT_W'(1);

    wd_state_t                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] limit_q;
    logic [NUM_SOURCES-1:0]   src_en_q;
    logic [SRC_W-1:0]         last_src_q, last_src_d;
    logic [EXPIRY_CNT_W-1:0]  expiries_q, expiries_d;
    logic                     timeout_n_q, timeout_n_d;

    logic                     any_kick;
    logic [SRC_W-1:0]         kick_idx;

    truss_kick_prio_enc #(
        .NUM_SOURCES(NUM_SOURCES)
    ) u_prio_enc (
        .req      (kick & src_en_q),
        .any_kick (any_kick),
        .index    (kick_idx)
    );

    assign cfg_ready = (state_q == WD_IDLE) || (state_q == WD_EXPIRED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit_q  <= '0;
            src_en_q <= '0;
        end else if (cfg_valid && cfg_ready) begin
            limit_q  <= cfg_limit;
            src_en_q <= cfg_src_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_src_d  = last_src_q;
        expiries_d  = expiries_q;
        timeout_n_d = timeout_n_q;

        if (disarm) begin
            state_d     = WD_IDLE;
            cnt_d       = '0;
            timeout_n_d = 1'b1;
        end else begin
            unique case (state_q)
                WD_IDLE: begin
                    if (arm && (|limit_q) && (|src_en_q)) begin
                        state_d = WD_ARMED;
                        cnt_d   = '0;
                    end
                end
                WD_ARMED: begin
                    if (arm) begin
                        cnt_d = '0;
                    end else if (any_kick) begin
                        cnt_d      = '0;
                        last_src_d = kick_idx;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        // Reaching the limit on this edge is the expiry; cnt never passes limit.
                        if (cnt_q == limit_q - CNT_ONE) begin
                            state_d     = WD_EXPIRED;
                            timeout_n_d = 1'b0;
                            if (expiries_q != EXP_MAX) begin
                                expiries_d = expiries_q + EXP_ONE;
                            end
                        end
                    end
                end
                WD_EXPIRED: begin
                end
                default: begin
                    state_d     = WD_IDLE;
                    cnt_d       = '0;
                    timeout_n_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WD_IDLE;
            cnt_q       <= '0;
            last_src_q  <= '0;
            expiries_q  <= '0;
            timeout_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_src_q  <= last_src_d;
            expiries_q  <= expiries_d;
            timeout_n_q <= timeout_n_d;
        end
    end

    assign hdl_timeout_       = timeout_n_q;
    assign hdl_timeout_count_ = cnt_q;
    assign last_src           = last_src_q;
    assign expiries           = expiries_q;
    assign state              = state_q;

endmodule

// File: tb/tb_truss_hdl_watchdog.sv
// Directed self-checking bench for truss_hdl_watchdog.
module tb_truss_hdl_watchdog;

    localparam int CW = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_limit = '0;
    logic [NS-1:0] cfg_src_en = '0;
    logic          arm = 1'b0;
    logic          disarm = 1'b0;
    logic [NS-1:0] kick = '0;
    logic          hdl_timeout_;
    logic [CW-1:0] hdl_timeout_count_;
    logic [1:0]    last_src;
    logic [7:0]    expiries;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    truss_hdl_watchdog #(
        .COUNTER_WIDTH(CW),
        .NUM_SOURCES  (NS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_limit         (cfg_limit),
        .cfg_src_en        (cfg_src_en),
        .arm               (arm),
        .disarm            (disarm),
        .kick              (kick),
        .hdl_timeout_      (hdl_timeout_),
        .hdl_timeout_count_(hdl_timeout_count_),
        .last_src          (last_src),
        .expiries          (expiries),
        .state             (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_timeout"}, 64'(hdl_timeout_), 64'd1);
        check({tag, "_count"}, 64'(hdl_timeout_count_), 64'd0);
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, "_last_src"}, 64'(last_src), 64'd0);
        check({tag, "_expiries"}, 64'(expiries), 64'd0);
    endtask

    task automatic configure(input logic [CW-1:0] lim, input logic [NS-1:0] en);
        cfg_limit  = lim;
        cfg_src_en = en;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] exp_cnt;
        logic [CW-1:0] max_cnt;
        logic          seen_expiry;

        // Reset with no stimulus
        #2 reset_n = 1'b0;
        #3;
        check_reset_values("reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_values("post_reset");

        // limit 10, no kicks: expiry exactly 10 edges after arm
        configure(32'd10, 4'b0001);
        pulse_arm();
        check("arm_state", 64'(state), 64'd1);
        check("arm_count", 64'(hdl_timeout_count_), 64'd0);
        check("armed_cfg_ready", 64'(cfg_ready), 64'd0);
        for (int k = 1; k <= 9; k++) tick();
        check("pre_expiry_count", 64'(hdl_timeout_count_), 64'd9);
        check("pre_expiry_timeout", 64'(hdl_timeout_), 64'd1);
        check("pre_expiry_state", 64'(state), 64'd1);
        tick();
        check("expiry_timeout", 64'(hdl_timeout_), 64'd0);
        check("expiry_count", 64'(hdl_timeout_count_), 64'd10);
        check("expiry_state", 64'(state), 64'd2);
        check("expiry_expiries", 64'(expiries), 64'd1);
        check("expired_cfg_ready", 64'(cfg_ready), 64'd1);
        kick = 4'b0001;
        arm  = 1'b1;
        tick();
        kick = '0;
        arm  = 1'b0;
        check("expired_ignore_count", 64'(hdl_timeout_count_), 64'd10);
        check("expired_ignore_state", 64'(state), 64'd2);
        check("expired_ignore_expiries", 64'(expiries), 64'd1);

        pulse_disarm();
        check("disarm_state", 64'(state), 64'd0);
        check("disarm_count", 64'(hdl_timeout_count_), 64'd0);
        check("disarm_timeout", 64'(hdl_timeout_), 64'd1);
        check("disarm_keeps_expiries", 64'(expiries), 64'd1);

        // Periodic kick on every 10th edge lands on the count=9 boundary
        pulse_arm();
        exp_cnt     = '0;
        max_cnt     = '0;
        seen_expiry = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            kick = (i % 10 == 0) ? 4'b0001 : 4'b0000;
            tick();
            exp_cnt = kick[0] ? '0 : exp_cnt + 1;
            if (hdl_timeout_count_ > max_cnt) max_cnt = hdl_timeout_count_;
            if (!hdl_timeout_ || state != 2'd1) seen_expiry = 1'b1;
            check("periodic_count", 64'(hdl_timeout_count_), 64'(exp_cnt));
        end
        kick = '0;
        check("periodic_no_expiry", 64'(seen_expiry), 64'd0);
        check("periodic_max_le_9", 64'(max_cnt <= 9), 64'd1);
        check("periodic_expiries", 64'(expiries), 64'd1);

        // Priority and masking
        pulse_disarm();
        configure(32'd10, 4'b1110);
        pulse_arm();
        kick = 4'b1100;
        tick();
        check("prio_last_src", 64'(last_src), 64'd2);
        check("prio_count", 64'(hdl_timeout_count_), 64'd0);
        kick = 4'b0001;
        for (int k = 1; k <= 9; k++) tick();
        check("masked_count9", 64'(hdl_timeout_count_), 64'd9);
        check("masked_state9", 64'(state), 64'd1);
        tick();
        kick = '0;
        check("masked_expiry_state", 64'(state), 64'd2);
        check("masked_expiry_count", 64'(hdl_timeout_count_), 64'd10);
        check("masked_expiries", 64'(expiries), 64'd2);
        check("masked_last_src", 64'(last_src), 64'd2);

        // Kick on the would-expire edge wins
        pulse_disarm();
        pulse_arm();
        for (int k = 1; k <= 9; k++) tick();
        check("boundary_pre_count", 64'(hdl_timeout_count_), 64'd9);
        kick = 4'b0010;
        tick();
        kick = '0;
        check("boundary_count", 64'(hdl_timeout_count_), 64'd0);
        check("boundary_state", 64'(state), 64'd1);
        check("boundary_timeout", 64'(hdl_timeout_), 64'd1);
        check("boundary_last_src", 64'(last_src), 64'd1);
        tick();
        check("rearm_restart_pre", 64'(hdl_timeout_count_), 64'd1);
        pulse_arm();
        check("rearm_restart_count", 64'(hdl_timeout_count_), 64'd0);
        check("rearm_restart_state", 64'(state), 64'd1);
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        check("disarm_over_arm_state", 64'(state), 64'd0);
        check("disarm_over_arm_count", 64'(hdl_timeout_count_), 64'd0);

        // Asynchronous reset while EXPIRED
        pulse_arm();
        for (int k = 1; k <= 10; k++) tick();
        check("pre_async_state", 64'(state), 64'd2);
        #1 reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        reset_n = 1'b1;
        tick();

        // arm with no config after reset, and with limit 0
        pulse_arm();
        check("arm_unconfigured_state", 64'(state), 64'd0);
        configure(32'd0, 4'b0001);
        pulse_arm();
        check("arm_limit0_state", 64'(state), 64'd0);
        check("arm_limit0_timeout", 64'(hdl_timeout_), 64'd1);
        configure(32'd5, 4'b0000);
        pulse_arm();
        check("arm_noen_state", 64'(state), 64'd0);

        // limit 1 expires on the first edge; expiries saturates at 255
        configure(32'd1, 4'b0001);
        for (int i = 1; i <= 260; i++) begin
            pulse_arm();
            tick();
            if (i == 1) begin
                check("limit1_state", 64'(state), 64'd2);
                check("limit1_count", 64'(hdl_timeout_count_), 64'd1);
            end
            if (i == 200) check("expiries_200", 64'(expiries), 64'd200);
            if (i == 255) check("expiries_255", 64'(expiries), 64'd255);
            pulse_disarm();
        end
        check("expiries_saturated", 64'(expiries), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
